// File: rtl/tree_node_builder.sv
// Insert-side node builder: allocates a node address from the space manager,
// writes a fresh leaf word there and reports the address/status downstream.
module tree_node_builder #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int KEY_WIDTH      = 8,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int TIMEOUT        = 64
) (
  input  logic                                                   aclk,
  input  logic                                                   aresetn,
  input  logic                                                   cmd_valid,
  output logic                                                   cmd_ready,
  input  logic [KEY_WIDTH-1:0]                                   cmd_key,
  input  logic [PAYLOAD_WIDTH-1:0]                               cmd_payload,
  output logic                                                   tree_mgt_req_valid,
  input  logic                                                   tree_mgt_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0]                              tree_mgt_req_addr,
  input  logic                                                   tree_mgt_full,
  output logic                                                   ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0]                              ram_addr,
  output logic [1+KEY_WIDTH+PAYLOAD_WIDTH+2*RAM_ADDR_WIDTH-1:0]  ram_wr_data,
  output logic                                                   node_valid,
  input  logic                                                   node_ready,
  output logic [RAM_ADDR_WIDTH-1:0]                              node_addr,
  output logic [1:0]                                             node_status
);

  localparam int WORD_W = 1 + KEY_WIDTH + PAYLOAD_WIDTH + 2 * RAM_ADDR_WIDTH;
  localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [RAM_ADDR_WIDTH-1:0] NULL_ADDR = {RAM_ADDR_WIDTH{1'b1}};
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_TMO  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic [KEY_WIDTH-1:0]        key_q, key_d;
  logic [PAYLOAD_WIDTH-1:0]    payload_q, payload_d;
  logic [RAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RAM_ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic [1:0]                  status_q, status_d;
  logic [TMR_W-1:0]            timer_q, timer_d;

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      key_q      <= {KEY_WIDTH{1'b0}};
      payload_q  <= {PAYLOAD_WIDTH{1'b0}};
      addr_q     <= {RAM_ADDR_WIDTH{1'b0}};
      res_addr_q <= NULL_ADDR;
      status_q   <= ST_OK;
      timer_q    <= {TMR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      payload_q  <= payload_d;
      addr_q     <= addr_d;
      res_addr_q <= res_addr_d;
      status_q   <= status_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state logic; a grant wins over full, which wins over timeout.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    payload_d  = payload_q;
    addr_d     = addr_q;
    res_addr_d = res_addr_q;
    status_d   = status_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          key_d     = cmd_key;
          payload_d = cmd_payload;
          if (tree_mgt_full) begin
            state_d    = S_RESP;
            status_d   = ST_FULL;
            res_addr_d = NULL_ADDR;
          end else begin
            state_d = S_REQ;
            timer_d = {TMR_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (tree_mgt_req_ready) begin
          addr_d  = tree_mgt_req_addr;
          state_d = S_WRITE;
        end else if (tree_mgt_full) begin
          state_d    = S_RESP;
          status_d   = ST_FULL;
          res_addr_d = NULL_ADDR;
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          state_d    = S_RESP;
          status_d   = ST_TMO;
          res_addr_d = NULL_ADDR;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      S_WRITE: begin
        state_d    = S_RESP;
        status_d   = ST_OK;
        res_addr_d = addr_q;
      end
      S_RESP: begin
        if (node_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and data.
  assign cmd_ready          = (state_q == S_IDLE);
  assign tree_mgt_req_valid = (state_q == S_REQ);
  assign ram_wr_en          = (state_q == S_WRITE);
  assign ram_addr           = addr_q;
  assign ram_wr_data        = (state_q == S_WRITE) ? {1'b1, key_q, payload_q, NULL_ADDR, NULL_ADDR}
                                                   : {WORD_W{1'b0}};
  assign node_valid         = (state_q == S_RESP);
  assign node_addr          = res_addr_q;
  assign node_status        = status_q;

endmodule

// File: doc/tree_node_builder.md
# tree_node_builder

Upstream client of the tree space manager in the BST engine. Accepts an insert-node command (key + payload), requests a free RAM address from the space manager, writes a fresh leaf node at that address, then returns the allocated address with a status code to the insert/link stage. Allocation failures (tree full, request timeout) are reported without touching RAM.

## Interface
- RAM_ADDR_WIDTH, 16, node address width; must match the space manager
- KEY_WIDTH, 8, key width in bits
- PAYLOAD_WIDTH, 32, payload width in bits
- TIMEOUT, 64, maximum REQ-state cycles before abort; 0 = wait forever
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  insert command valid
- cmd_ready  out  1  block can accept a command
- cmd_key  in  KEY_WIDTH  key of the new node
- cmd_payload  in  PAYLOAD_WIDTH  payload of the new node
- tree_mgt_req_valid  out  1  address request to the space manager
- tree_mgt_req_ready  in  1  space manager grants the request this cycle
- tree_mgt_req_addr  in  RAM_ADDR_WIDTH  granted address; sampled when valid && ready
- tree_mgt_full  in  1  space manager has no free address
- ram_wr_en  out  1  node RAM write strobe
- ram_addr  out  RAM_ADDR_WIDTH  node RAM write address
- ram_wr_data  out  1+KEY_WIDTH+PAYLOAD_WIDTH+2*RAM_ADDR_WIDTH  node word {used, key, payload, left, right}
- node_valid  out  1  result valid
- node_ready  in  1  downstream accepts the result
- node_addr  out  RAM_ADDR_WIDTH  allocated address, NULL on failure
- node_status  out  2  0 = OK, 1 = FULL, 2 = TIMEOUT, 3 = reserved (never driven)

## Operation
- NULL = all ones ({RAM_ADDR_WIDTH{1'b1}}); root address 0 is a valid allocation.
- Node word written: used = 1, captured key, captured payload, left = NULL, right = NULL.
- FSM states IDLE, REQ, WRITE, RESP; state register reset to IDLE.
- IDLE: cmd_ready = 1. On cmd_valid: capture key/payload; if tree_mgt_full = 1 that cycle -> RESP with FULL, else -> REQ with timer cleared.
- REQ: tree_mgt_req_valid = 1. Priority per cycle: (1) tree_mgt_req_ready = 1 -> latch tree_mgt_req_addr, -> WRITE; (2) tree_mgt_full = 1 -> RESP, FULL; (3) TIMEOUT != 0 and timer == TIMEOUT-1 -> RESP, TIMEOUT; else timer++.
- Timer width $clog2(TIMEOUT+1), saturating; unused when TIMEOUT = 0.
- WRITE: ram_wr_en = 1 for exactly one cycle with ram_addr = latched address; -> RESP, OK.
- RESP: node_valid = 1, node_addr/node_status held stable until node_ready = 1; then -> IDLE.
- Failure results carry node_addr = NULL; no RAM write ever occurs on failure.
- One command in flight; cmd_ready = 0 in REQ, WRITE, RESP.
- tree_mgt_req_valid deasserts the cycle after a grant; exactly one grant consumed per command.

## Timing
- Reset values: cmd_ready = 1 (IDLE), tree_mgt_req_valid = 0, ram_wr_en = 0, ram_addr = 0, ram_wr_data = 0, node_valid = 0, node_addr = NULL, node_status = 0.
- Outputs decoded from registered state/data; no combinational path from any input to any output.
- Best case (grant on first REQ cycle): command accepted cycle 0, req_valid cycle 1, ram_wr_en cycle 2, node_valid cycle 3; next command accepted no earlier than cycle 4.
- FULL at accept: node_valid at cycle 1.
- TIMEOUT: node_valid appears TIMEOUT cycles after the first REQ cycle.
- node_ready high on the first RESP cycle: node_valid lasts one cycle, cmd_ready returns the next cycle.
- Reset mid-operation: FSM returns to IDLE immediately, pending request/result discarded, all outputs take reset values.

## Test plan
- Grant immediately, key 0x5A, payload 0xDEADBEEF, granted addr 0x0000 -> write at cycle 2 with word {1,0x5A,0xDEADBEEF,0xFFFF,0xFFFF}; node_addr 0x0000, status 0 at cycle 3.
- Grant delayed 5 cycles, addr 0x0007 -> req_valid held 6 cycles, single write at 0x0007, status OK.
- tree_mgt_full = 1 at accept -> no req_valid, no write, node_addr 0xFFFF, status 1 at cycle 1.
- TIMEOUT = 4, ready never asserted -> req_valid high exactly 4 cycles, status 2, addr 0xFFFF, no write.
- node_ready held low 10 cycles in RESP -> node_valid/addr/status stable; cmd_valid ignored (cmd_ready = 0).
- aresetn pulsed low during REQ -> all outputs at reset values next edge; subsequent command completes normally with one grant.
